// File: rtl/fp_pkg.sv
// Shared bfloat16 definitions for the operand path and the FP add/mul unit.
package fp_pkg;

  localparam int BF16_BIAS   = 127;
  localparam int BF16_EXP_W  = 8;
  localparam int BF16_FRAC_W = 7;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

endpackage : fp_pkg

// File: rtl/int_to_bf16.sv
// Signed integer to bfloat16 encoder. The magnitude is normalised one bit per
// clock by left-shifting until its MSB is set; the fraction is truncated.
module int_to_bf16
  import fp_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int EXP_W  = BF16_EXP_W,
  parameter int FRAC_W = BF16_FRAC_W,
  parameter int BIAS   = BF16_BIAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [INT_W-1:0] in_int,
  output logic             in_ready,
  output logic             out_valid,
  output logic [INT_W-1:0] out
);

  localparam int CNT_W = $clog2(INT_W);
  // An unshifted magnitude has its top bit at weight 2^(INT_W-1).
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + INT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(INT_W - 1);

  state_t           state, state_next;
  logic             sign;
  logic [INT_W-1:0] mag;
  logic [EXP_W-1:0] exp;
  logic [CNT_W-1:0] cnt;
  logic [INT_W-1:0] abs_in;
  bf16_t            result;

  // Two's-complement magnitude; the most negative input maps to its own bit pattern.
  assign abs_in = in_int[INT_W-1] ? (~in_int + 1'b1) : in_int;

  // Packed result once the hidden one sits in the MSB of mag.
  assign result = {sign, exp, mag[INT_W-2 -: FRAC_W]};

  assign in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: leave NORM once the magnitude is zero or normalised.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = NORM;
      NORM: if ((mag == '0) || mag[INT_W-1]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift/decrement while normalising, emit result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      mag       <= '0;
      exp       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= '0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_int[INT_W-1];
            mag  <= abs_in;
            exp  <= EXP_INIT;
            cnt  <= '0;
          end
        end
        NORM: begin
          if (mag == '0) begin
            out_valid <= 1'b1;
          end else if (mag[INT_W-1]) begin
            out       <= result;
            out_valid <= 1'b1;
          end else begin
            mag <= mag << 1;
            exp <= exp - 1'b1;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : int_to_bf16

// File: tb/tb_int_to_bf16.sv
// Bench for int_to_bf16: arithmetic reference model checked every cycle,
// plus directed conversions with hand-computed results and latencies.
module tb_int_to_bf16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_int = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;

  int n_checks = 0;
  int n_errors = 0;

  int_to_bf16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_int   (in_int),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truncating encode from the numeric value: exponent = floor(log2 |x|).
  function automatic logic [15:0] ref_bf16(input logic [15:0] x);
    int v, m, e, frac;
    bit s;
    v = int'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 16'h0000;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e >= 7) frac = (m >> (e - 7)) & 127;
    else        frac = (m << (7 - e)) & 127;
    return {s, 8'(127 + e), 7'(frac)};
  endfunction

  // Edges from accept to result: one plus the leading zeros of the 16-bit magnitude.
  function automatic int ref_lat(input logic [15:0] x);
    int v, m, e;
    v = int'($signed(x));
    m = (v < 0) ? -v : v;
    if (m == 0) return 1;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return 1 + (15 - e);
  endfunction

  // Reference model, advanced on the falling edge using the inputs the next rising edge will see.
  bit          m_idle = 1'b1;
  bit          m_ov = 1'b0;
  logic [15:0] m_out = 16'h0000;
  logic [15:0] m_res = 16'h0000;
  int          m_remain = 0;
  int          m_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1;
      m_ov   = 1'b0;
      m_out  = 16'h0000;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out", 32'(out), 32'd0);
    end else begin
      check("model out_valid", 32'(out_valid), 32'(m_ov));
      check("model out", 32'(out), 32'(m_out));
      check("model in_ready", 32'(in_ready), 32'(m_idle));
      m_ov  = 1'b0;
      m_out = 16'h0000;
      if (m_idle) begin
        if (in_valid) begin
          m_idle   = 1'b0;
          m_res    = ref_bf16(in_int);
          m_remain = ref_lat(in_int);
        end
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          m_ov   = 1'b1;
          m_out  = m_res;
          m_idle = 1'b1;
          m_done++;
        end
      end
    end
  end

  // All directed tasks run at #1 after a rising edge.
  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
  endtask

  // Called right after the accept edge; counts edges to the result pulse.
  task automatic wait_result(input logic [15:0] exp_out, input int exp_lat, input string name);
    int lat;
    bit got;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    check({name, " seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " value"}, 32'(out), 32'(exp_out));
  endtask

  task automatic convert(input logic [15:0] v, input logic [15:0] exp_out, input int exp_lat,
                         input string name);
    wait_idle();
    in_valid = 1'b1;
    in_int   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_int   = 16'($urandom);
    wait_result(exp_out, exp_lat, name);
  endtask

  initial begin
    int pulses;
    int lat;
    int target;
    int budget;

    // Model pinned against hand-computed encodings.
    check("ref 1", 32'(ref_bf16(16'd1)), 32'h3F80);
    check("ref 300", 32'(ref_bf16(16'd300)), 32'h4396);
    check("ref 32767", 32'(ref_bf16(16'h7FFF)), 32'h46FF);
    check("ref -32768", 32'(ref_bf16(16'h8000)), 32'hC700);
    check("ref lat 1", 32'(ref_lat(16'd1)), 32'd16);

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", 32'(in_ready), 32'd1);
    check("idle out", 32'(out), 32'd0);

    convert(16'd1,      16'h3F80, 16, "one");
    convert(16'h8000,   16'hC700, 1,  "min_neg");
    convert(16'd0,      16'h0000, 1,  "zero");
    convert(16'd300,    16'h4396, 8,  "three_hundred");
    convert(16'h7FFF,   16'h46FF, 2,  "max_pos");
    convert(16'hFFFF,   16'hBF80, 16, "minus_one");

    // in_valid held high with changing data during NORM; next accept in the result cycle.
    wait_idle();
    in_valid = 1'b1;
    in_int   = 16'd300;
    @(posedge clk); #1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      in_int = 16'($urandom);
    end
    check("hold latency", 32'(lat), 32'd8);
    check("hold value", 32'(out), 32'h4396);
    check("hold in_ready in result cycle", 32'(in_ready), 32'd1);
    in_int = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(16'hBF80, 16, "back_to_back");

    // Reset three cycles into converting 1 aborts it.
    wait_idle();
    in_valid = 1'b1;
    in_int   = 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out", 32'(out), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort no pulse", 32'(pulses), 32'd0);
    convert(16'd300, 16'h4396, 8, "after_abort");

    // Random stream checked by the per-cycle model.
    target = m_done + 2000;
    budget = 0;
    while ((m_done < target) && (budget < 40000)) begin
      in_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: in_int = 16'($urandom) >> $urandom_range(0, 15);
        1: begin
          case ($urandom_range(0, 4))
            0: in_int = 16'h0000;
            1: in_int = 16'h0001;
            2: in_int = 16'hFFFF;
            3: in_int = 16'h8000;
            default: in_int = 16'h7FFF;
          endcase
        end
        default: in_int = 16'($urandom);
      endcase
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    check("random conversions done", 32'(m_done >= target), 32'd1);
    repeat (20) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_int_to_bf16
